// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-point sign-magnitude arithmetic blocks.
package fp_pkg;

   localparam logic RND_TRUNC   = 1'b0;
   localparam logic RND_HALF_UP = 1'b1;

   // Largest representable magnitude for a SIZE-bit sign-magnitude word.
   function automatic logic [63:0] fp_max_mag(input int unsigned size);
      return (64'(1) << (size - 1)) - 64'(1);
   endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Round, rescale and overflow-handle a full-width magnitude product.
module fp_round_sat
   import fp_pkg::*;
#(
   parameter int unsigned SIZE = 24,
   parameter int unsigned FRAC = 8
) (
   input  logic [2*(SIZE-1)-1:0] p,
   input  logic                  rnd,
   input  logic                  sat,
   output logic [SIZE-2:0]       mag,
   output logic                  ovf
);

   localparam int unsigned MW = SIZE - 1;
   localparam int unsigned PW = 2 * MW;

   // Half an output LSB; collapses to zero when there are no fractional bits.
   localparam logic [PW:0] HALF = ((PW+1)'(1) << FRAC) >> 1;
   localparam logic [PW:0] MAXM = (PW+1)'(fp_max_mag(SIZE));

   logic [PW:0] sum;
   logic [PW:0] m;

   always_comb begin
      sum = {1'b0, p} + ((rnd == RND_HALF_UP) ? HALF : '0);
      m   = sum >> FRAC;
      ovf = (m > MAXM);
      mag = m[MW-1:0];
      if (ovf && sat) begin
         mag = MW'(fp_max_mag(SIZE));
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined sign-magnitude fixed-point multiplier with a single global stall.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int unsigned SIZE   = 24,
   parameter int unsigned FRAC   = 8,
   parameter int unsigned STAGES = 2,
   parameter int unsigned SAT    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] in_a,
   input  logic [SIZE-1:0] in_b,
   input  logic            in_round,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_p,
   output logic            out_ovf
);

   localparam int unsigned MW = SIZE - 1;
   localparam int unsigned PW = 2 * MW;

   logic adv;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Multiplier operands: straight from the ports, or from the stage-1 register.
   logic [MW-1:0] m_a, m_b;
   logic          m_r, m_s, m_v;

   generate
      if (STAGES == 1) begin : g_in_comb
         assign m_a = in_a[MW-1:0];
         assign m_b = in_b[MW-1:0];
         assign m_r = in_round;
         assign m_s = in_a[SIZE-1] ^ in_b[SIZE-1];
         assign m_v = in_valid;
      end else begin : g_in_reg
         logic [MW-1:0] s1_a, s1_b;
         logic          s1_r, s1_s, s1_v;

         always_ff @(posedge clk) begin
            if (rst) begin
               s1_a <= '0;
               s1_b <= '0;
               s1_r <= 1'b0;
               s1_s <= 1'b0;
               s1_v <= 1'b0;
            end else if (adv) begin
               s1_a <= in_a[MW-1:0];
               s1_b <= in_b[MW-1:0];
               s1_r <= in_round;
               s1_s <= in_a[SIZE-1] ^ in_b[SIZE-1];
               s1_v <= in_valid;
            end
         end

         assign m_a = s1_a;
         assign m_b = s1_b;
         assign m_r = s1_r;
         assign m_s = s1_s;
         assign m_v = s1_v;
      end
   endgenerate

   logic [PW-1:0] prod;

   assign prod = PW'(m_a) * PW'(m_b);

   // Product feeding round/saturate: direct, or through the product delay chain.
   logic [PW-1:0] f_p;
   logic          f_r, f_s, f_v;

   generate
      if (STAGES <= 2) begin : g_prod_comb
         assign f_p = prod;
         assign f_r = m_r;
         assign f_s = m_s;
         assign f_v = m_v;
      end else begin : g_prod_reg
         localparam int unsigned ND = STAGES - 2;

         logic [PW-1:0] d_p [ND];
         logic          d_r [ND];
         logic          d_s [ND];
         logic          d_v [ND];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < int'(ND); i++) begin
                  d_p[i] <= '0;
                  d_r[i] <= 1'b0;
                  d_s[i] <= 1'b0;
                  d_v[i] <= 1'b0;
               end
            end else if (adv) begin
               d_p[0] <= prod;
               d_r[0] <= m_r;
               d_s[0] <= m_s;
               d_v[0] <= m_v;
               for (int i = 1; i < int'(ND); i++) begin
                  d_p[i] <= d_p[i-1];
                  d_r[i] <= d_r[i-1];
                  d_s[i] <= d_s[i-1];
                  d_v[i] <= d_v[i-1];
               end
            end
         end

         assign f_p = d_p[ND-1];
         assign f_r = d_r[ND-1];
         assign f_s = d_s[ND-1];
         assign f_v = d_v[ND-1];
      end
   endgenerate

   logic [MW-1:0] rs_mag;
   logic          rs_ovf;

   fp_round_sat #(
      .SIZE (SIZE),
      .FRAC (FRAC)
   ) u_round_sat (
      .p   (f_p),
      .rnd (f_r),
      .sat (1'(SAT)),
      .mag (rs_mag),
      .ovf (rs_ovf)
   );

   // Output register; a zero magnitude always leaves with a positive sign.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_ovf   <= 1'b0;
      end else if (adv) begin
         out_valid <= f_v;
         out_p     <= {f_s && (rs_mag != '0), rs_mag};
         out_ovf   <= rs_ovf;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboarded bench for fp_mul_pipe: a saturating and a wrapping instance share one stimulus stream.
module tb_fp_mul_pipe;

   localparam int unsigned SIZE   = 24;
   localparam int unsigned FRAC   = 8;
   localparam int unsigned STAGES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_round, out_ready;
   logic [23:0] in_a, in_b;
   logic        in_ready, out_valid, out_ovf;
   logic [23:0] out_p;
   logic        w_in_ready, w_out_valid, w_out_ovf;
   logic [23:0] w_out_p;

   fp_mul_pipe #(.SIZE(SIZE), .FRAC(FRAC), .STAGES(STAGES), .SAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_round(in_round),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_ovf(out_ovf)
   );

   fp_mul_pipe #(.SIZE(SIZE), .FRAC(FRAC), .STAGES(STAGES), .SAT(0)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_a(in_a), .in_b(in_b), .in_round(in_round),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_p(w_out_p), .out_ovf(w_out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] ps;
      logic [23:0] pw;
      logic        ovf;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_pops   = 0;
   bit   mon_en   = 1'b0;

   // Reference: exact 64-bit arithmetic, then saturate or wrap.
   function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input logic r);
      logic [63:0] pm, m;
      logic [22:0] ms, mw;
      logic        sg;
      exp_t        e;
      pm = 64'(a[22:0]) * 64'(b[22:0]);
      if (r) pm = pm + (64'(1) << (FRAC - 1));
      m     = pm >> FRAC;
      e.ovf = (m > 64'h7F_FFFF);
      sg    = a[23] ^ b[23];
      ms    = e.ovf ? 23'h7F_FFFF : m[22:0];
      mw    = m[22:0];
      e.ps  = {sg && (ms != 23'd0), ms};
      e.pw  = {sg && (mw != 23'd0), mw};
      return e;
   endfunction

   // Scoreboard: every retired result must match the oldest accepted pair.
   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         n_checks++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output got p=%h ovf=%b, expected no output", out_p, out_ovf);
         end else begin
            mon_e = q.pop_front();
            n_pops++;
            if ({out_p, out_ovf, w_out_p, w_out_ovf, w_out_valid} !==
                {mon_e.ps, mon_e.ovf, mon_e.pw, mon_e.ovf, 1'b1}) begin
               n_err++;
               $display("FAIL scoreboard got sat=%h/%b wrap=%h/%b wvalid=%b, expected sat=%h wrap=%h ovf=%b",
                        out_p, out_ovf, w_out_p, w_out_ovf, w_out_valid, mon_e.ps, mon_e.pw, mon_e.ovf);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // Present one pair; returns just after the edge that transferred it.
   task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic r);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_round = r;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL drive_accept in_ready=0, expected 1 within 64 cycles");
      end else begin
         q.push_back(model(a, b, r));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic one_shot(input logic [23:0] a, input logic [23:0] b, input logic r,
                           output logic [23:0] ps, output logic [23:0] pw, output logic ov);
      bit got = 1'b0;
      ps = '0;
      pw = '0;
      ov = 1'b0;
      drive(a, b, r);
      in_valid = 1'b0;
      for (int k = 0; k < 32 && !got; k++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            ps  = out_p;
            pw  = w_out_p;
            ov  = out_ovf;
         end
      end
      n_checks++;
      if (!got) begin
         n_err++;
         $display("FAIL result_timeout out_valid=0, expected 1 within 32 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid got %b/%b, expected 0/0", out_valid, w_out_valid);
      end
      n_checks++;
      if (out_p !== 24'h0 || out_ovf !== 1'b0 || w_out_p !== 24'h0 || w_out_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL reset_data got %h/%b %h/%b, expected 0", out_p, out_ovf, w_out_p, w_out_ovf);
      end
      n_checks++;
      if (in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready got %b/%b, expected 1/1", in_ready, w_in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      drive(24'h000180, 24'h000200, 1'b0);
      in_valid = 1'b0;
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early out_valid=%b at cycle %0d, expected 0", out_valid, k);
         end
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_p !== 24'h000300 || out_ovf !== 1'b0 || w_out_p !== 24'h000300) begin
         n_err++;
         $display("FAIL basic_latency got v=%b p=%h ovf=%b wp=%h, expected v=1 p=000300 ovf=0",
                  out_valid, out_p, out_ovf, w_out_p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sign();
      logic [23:0] ps, pw;
      logic        ov;
      one_shot(24'h800180, 24'h000200, 1'b0, ps, pw, ov);
      n_checks++;
      if (ps !== 24'h800300 || pw !== 24'h800300 || ov !== 1'b0) begin
         n_err++;
         $display("FAIL sign_neg got %h/%h/%b, expected 800300/800300/0", ps, pw, ov);
      end
      one_shot(24'h800000, 24'h000100, 1'b0, ps, pw, ov);
      n_checks++;
      if (ps !== 24'h000000 || pw !== 24'h000000 || ov !== 1'b0) begin
         n_err++;
         $display("FAIL neg_zero_in got %h/%h/%b, expected 000000/000000/0", ps, pw, ov);
      end
      one_shot(24'h808000, 24'h010000, 1'b0, ps, pw, ov);
      n_checks++;
      if (ps !== 24'hFFFFFF || pw !== 24'h000000 || ov !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_to_zero got %h/%h/%b, expected FFFFFF/000000/1", ps, pw, ov);
      end
   endtask

   task automatic test_round();
      logic [23:0] ps, pw;
      logic        ov;
      one_shot(24'h000001, 24'h000080, 1'b1, ps, pw, ov);
      n_checks++;
      if (ps !== 24'h000001 || pw !== 24'h000001 || ov !== 1'b0) begin
         n_err++;
         $display("FAIL round_half_up got %h/%h/%b, expected 000001/000001/0", ps, pw, ov);
      end
      one_shot(24'h000001, 24'h000080, 1'b0, ps, pw, ov);
      n_checks++;
      if (ps !== 24'h000000 || pw !== 24'h000000 || ov !== 1'b0) begin
         n_err++;
         $display("FAIL round_trunc got %h/%h/%b, expected 000000/000000/0", ps, pw, ov);
      end
   endtask

   task automatic test_overflow();
      logic [23:0] ps, pw;
      logic        ov;
      one_shot(24'h7FFFFF, 24'h000200, 1'b0, ps, pw, ov);
      n_checks++;
      if (ps !== 24'h7FFFFF || pw !== 24'h7FFFFE || ov !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_sat_wrap got %h/%h/%b, expected 7FFFFF/7FFFFE/1", ps, pw, ov);
      end
      one_shot(24'hFFFFFF, 24'h000100, 1'b0, ps, pw, ov);
      n_checks++;
      if (ps !== 24'hFFFFFF || pw !== 24'hFFFFFF || ov !== 1'b0) begin
         n_err++;
         $display("FAIL max_no_ovf got %h/%h/%b, expected FFFFFF/FFFFFF/0", ps, pw, ov);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] va[8], vb[8];
      logic        vr[8];
      int          pops0;
      logic [23:0] hold_p, hold_w;
      logic        hold_o;
      for (int i = 0; i < 8; i++) begin
         va[i] = {1'($urandom), 23'($urandom_range(0, 32'h3F_FFFF))};
         vb[i] = {1'($urandom), 23'($urandom_range(0, 32'h0_FFFF))};
         vr[i] = 1'($urandom);
      end
      pops0 = n_pops;
      hold_p = '0;
      hold_w = '0;
      hold_o = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) drive(va[i], vb[i], vr[i]);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               if (i == 0) begin
                  hold_p = out_p;
                  hold_w = w_out_p;
                  hold_o = out_ovf;
               end
               n_checks++;
               if (out_valid !== 1'b1 || in_ready !== 1'b0 || w_in_ready !== 1'b0) begin
                  n_err++;
                  $display("FAIL stall_ready got v=%b rdy=%b/%b, expected v=1 rdy=0/0",
                           out_valid, in_ready, w_in_ready);
               end
               n_checks++;
               if (out_p !== hold_p || w_out_p !== hold_w || out_ovf !== hold_o) begin
                  n_err++;
                  $display("FAIL stall_stable got %h/%h/%b, expected %h/%h/%b",
                           out_p, w_out_p, out_ovf, hold_p, hold_w, hold_o);
               end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
      #1;
      n_checks++;
      if (n_pops - pops0 !== 8 || q.size() != 0) begin
         n_err++;
         $display("FAIL stream_count got %0d results (%0d pending), expected 8 (0 pending)",
                  n_pops - pops0, q.size());
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      for (int i = 0; i < int'(STAGES); i++) drive(24'h000400 + 24'(i), 24'h000300, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || w_out_valid !== 1'b0 || out_p !== 24'h0 || out_ovf !== 1'b0 ||
          in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midflight_reset got v=%b/%b p=%h ovf=%b rdy=%b, expected 0/0 000000 0 1",
                  out_valid, w_out_valid, out_p, out_ovf, in_ready);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_result got v=%b/%b at cycle %0d, expected 0/0", out_valid, w_out_valid, k);
         end
      end
      @(posedge clk);
      #1;
      drive(24'h000300, 24'h800080, 1'b0);
      in_valid = 1'b0;
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_early out_valid=%b at cycle %0d, expected 0", out_valid, k);
         end
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_p !== 24'h800180 || w_out_p !== 24'h800180 || out_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_result got v=%b p=%h wp=%h ovf=%b, expected 1 800180 800180 0",
                  out_valid, out_p, w_out_p, out_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_round  = 1'b0;
      out_ready = 1'b1;
      test_reset();
      mon_en = 1'b1;
      test_basic();
      test_sign();
      test_round();
      test_overflow();
      test_back_to_back();
      test_reset_midflight();
      repeat (4) @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL final_drain got %0d pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Pipelined, parametrised sign-magnitude fixed-point multiplier for the Mode 7 affine datapath (matrix × screen-coordinate products). It accepts one operand pair per cycle under a valid/ready handshake and returns the product after a fixed, parameterised latency. Each transaction selects rounding mode. The block can saturate on overflow and flags it. It replaces the single-cycle combinational multiplier wherever a product crosses a register boundary.

## Interface
- `SIZE`, 24: total word width; bit SIZE-1 is the sign, bits SIZE-2:0 are the magnitude.
- `FRAC`, 8: number of fractional bits; 0 ≤ FRAC ≤ SIZE-2.
- `STAGES`, 2: pipeline register stages; legal range 1..4.
- `SAT`, 1: 1 = saturate magnitude on overflow; 0 = wrap (keep the low SIZE-1 bits).
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: the operand pair is valid.
- `in_ready`  out  1: the block accepts the pair this cycle.
- `in_a`, `in_b`  in  SIZE: sign-magnitude operands.
- `in_round`  in  1: 1 = round half-up; 0 = truncate. Sampled with the operands.
- `out_valid`  out  1: the result is valid.
- `out_ready`  in  1: the consumer accepts the result.
- `out_p`  out  SIZE: sign-magnitude product.
- `out_ovf`  out  1: the magnitude exceeded 2^(SIZE-1)-1 before saturation or wrap.

## Operation
- Magnitude product: P = a[SIZE-2:0] × b[SIZE-2:0], width 2(SIZE-1), unsigned, no loss.
- Rounding:
  - When in_round=1 and FRAC>0, add 2^(FRAC-1) to P, with the carry kept.
  - Then M = P >> FRAC.
- Overflow: ovf = (M > 2^(SIZE-1)-1).
  - SAT=1: magnitude = all ones.
  - SAT=0: magnitude = M[SIZE-2:0].
- Sign: a[SIZE-1] ^ b[SIZE-1], forced to 0 when the final magnitude is 0. Negative zero is never emitted.
- Negative-zero inputs (sign=1, magnitude=0) are treated as zero.
- Pipeline:
  - One global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, and is combinational from out_valid/out_ready only.
  - The valid bit travels with data through the stages. Bubbles are carried, not collapsed.
  - When adv=0, every stage holds its data, valid bit and ovf bit unchanged.
- Arithmetic split across stages:
  - Stage 1 registers the operands, round bit and sign.
  - The multiply is registered at stage min(2, STAGES).
  - Round, shift and saturate feed the final output register.
  - With STAGES=1, all arithmetic is combinational into a single register.
  - Any extra stages (3–4) are delay registers placed after the product.

## Timing
- Latency: a pair accepted at edge N, with no stall, gives out_valid=1 on the cycle after edge N+STAGES-1, i.e. STAGES cycles.
- Throughput: one result per cycle while out_ready=1.
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - out_p and out_ovf are stable while out_valid=1 and out_ready=0.
  - in_valid may drop at any time without a transfer.
- Simultaneous events: when out_ready=1 and in_valid=1 on the same cycle and the pipe is full, the output retires and the input enters in that same cycle, with no bubble.
- Reset:
  - At the first edge with rst=1, all valid bits clear.
  - out_valid=0, out_p=0, out_ovf=0.
  - in_ready=1 on the cycle after reset.
  - Data registers are also cleared, to 0.
  - Reset mid-operation discards all in-flight products. No partial output appears.

## Structure
- Shared package `fp_pkg`:
  - `RND_TRUNC=1'b0`, `RND_HALF_UP=1'b1`.
  - Helper function `fp_max_mag(SIZE)` returning 2^(SIZE-1)-1.
- Sub-module `fp_round_sat` (combinational):
  - Inputs: P, round bit, SAT.
  - Outputs: magnitude and ovf.
  - Reused by the planned fp_mac block.

## Test plan
- Basic, SIZE=24, FRAC=8, round=0: a=0x000180 (1.5), b=0x000200 (2.0) -> out_p=0x000300, out_ovf=0, out_valid exactly STAGES cycles after acceptance.
- Sign and negative zero:
  - a=0x800180, b=0x000200 -> 0x800300.
  - a=0x800000, b=0x000100 -> 0x000000.
- Rounding: a=0x000001, b=0x000080 (P=0x80) -> round=1 gives 0x000001; round=0 gives 0x000000.
- Overflow:
  - a=0x7FFFFF, b=0x000200, SAT=1 -> 0x7FFFFF, ovf=1.
  - Same operands with SAT=0 -> 0x7FFFFE, ovf=1.
- Backpressure:
  - Stream 8 back-to-back pairs.
  - Hold out_ready=0 for 3 cycles mid-stream; in_ready=0 while the pipe is full and out_valid=1.
  - All 8 results are delivered in order, none lost or duplicated, and outputs stay stable during the stall.
- Reset mid-flight: assert rst for 1 cycle with STAGES products in flight -> out_valid=0 on the next cycle, no stale result ever appears, and a new pair gives the correct result with full latency.
